// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned N x N -> 2N multiply and N / N divide with remainder, one bit per cycle.
// Latency: accept edge, N iteration edges, one fix-up edge; done pulses in the cycle after the fix-up edge.
// Backpressure: start is taken only while busy=0; start during busy is dropped, flush aborts without done.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   start, func, a, b    launch request; func[1]=divide, func[0]=signed operands
//   flush                abort an in-flight operation (no done, outputs keep old values)
//   busy, done           operation in flight / one-cycle result-valid pulse
//   y, yhigh             product low/high half, or quotient/remainder
//   zero, negative, overflow, div_by_zero   result flags, held until the next completion
module iter_muldiv #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   func,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic [N-1:0] yhigh,
    output logic         zero,
    output logic         negative,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            commit;

    logic [CW-1:0]   cnt;
    logic            op_div;
    logic            op_sgn;
    logic            neg_q;      // sign of product / quotient
    logic            neg_r;      // sign of remainder (dividend sign)
    logic            b_zero;
    logic            div_ovf;
    logic [N-1:0]    a_raw;      // returned unmodified as remainder on divide by zero
    logic [N-1:0]    m;          // multiplicand magnitude (mul) or divisor magnitude (div)
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*N-1:0]  acc;

    // Operand magnitudes at launch
    logic            a_neg;
    logic            b_neg;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;

    assign a_neg = func[0] & a[N-1];
    assign b_neg = func[0] & b[N-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One iteration of each algorithm
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_nxt;
    logic [N:0]      div_sh;
    logic [N:0]      div_diff;
    logic [2*N-1:0]  div_nxt;

    assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, m} : {(N+1){1'b0}});
    assign mul_nxt  = {mul_sum, acc[N-1:1]};
    assign div_sh   = {acc[2*N-1:N], acc[N-1]};
    assign div_diff = div_sh - {1'b0, m};
    // Borrow out of the N+1-bit subtract means the trial remainder was smaller than the divisor.
    assign div_nxt  = div_diff[N] ? {div_sh[N-1:0],   acc[N-2:0], 1'b0}
                                  : {div_diff[N-1:0], acc[N-2:0], 1'b1};

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
                commit    = !flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Sign correction and flags, registered on the fix-up edge
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quo_fix;
    logic [N-1:0]    rem_fix;
    logic [N-1:0]    res_y;
    logic [N-1:0]    res_yh;
    logic            res_z;
    logic            res_n;
    logic            res_o;
    logic            res_d;

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[N-1:0] : acc[N-1:0];
    assign rem_fix  = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];

    always_comb begin
        res_y  = '0;
        res_yh = '0;
        res_z  = 1'b0;
        res_n  = 1'b0;
        res_o  = 1'b0;
        res_d  = 1'b0;
        if (op_div) begin
            if (b_zero) begin
                res_y  = '1;
                res_yh = a_raw;
                res_d  = 1'b1;
            end else begin
                // Most-negative / -1 naturally yields the most-negative quotient and zero remainder.
                res_y  = quo_fix;
                res_yh = rem_fix;
                res_o  = div_ovf;
            end
            res_z = (res_y == '0);
            res_n = res_y[N-1];
        end else begin
            res_y  = prod_fix[N-1:0];
            res_yh = prod_fix[2*N-1:N];
            res_z  = (prod_fix == '0);
            res_n  = prod_fix[2*N-1];
            res_o  = op_sgn ? (res_yh != {N{res_y[N-1]}}) : (res_yh != '0);
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            op_div      <= 1'b0;
            op_sgn      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            div_ovf     <= 1'b0;
            a_raw       <= '0;
            m           <= '0;
            acc         <= '0;
            done        <= 1'b0;
            y           <= '0;
            yhigh       <= '0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                cnt     <= CW'(N-1);
                op_div  <= func[1];
                op_sgn  <= func[0];
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                b_zero  <= (b == '0);
                div_ovf <= func[0] && (a == MOST_NEG) && (b == '1);
                a_raw   <= a;
                m       <= func[1] ? b_mag : a_mag;
                acc     <= func[1] ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, b_mag};
            end else if (state == RUN && !flush) begin
                acc <= op_div ? div_nxt : mul_nxt;
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end
            if (commit) begin
                y           <= res_y;
                yhigh       <= res_yh;
                zero        <= res_z;
                negative    <= res_n;
                overflow    <= res_o;
                div_by_zero <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;
    localparam int N = 16;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   func;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic [N-1:0] yhigh;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_muldiv #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .func(func), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .y(y), .yhigh(yhigh), .zero(zero),
        .negative(negative), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    typedef struct packed {
        logic [N-1:0] y;
        logic [N-1:0] yh;
        logic         z;
        logic         n;
        logic         o;
        logic         d;
    } res_t;

    typedef struct {
        logic [1:0]   f;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } op_t;

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic res_t model(input logic [1:0] f, input logic [N-1:0] ia, input logic [N-1:0] ib);
        res_t   r;
        longint sa, sb, p, q, rm, lim;
        logic [63:0] pv;
        r = '0;
        if (f[0]) begin
            sa = longint'($signed(ia));
            sb = longint'($signed(ib));
        end else begin
            sa = longint'({48'd0, ia});
            sb = longint'({48'd0, ib});
        end
        if (!f[1]) begin
            p    = sa * sb;
            pv   = p;
            r.y  = pv[N-1:0];
            r.yh = pv[2*N-1:N];
            lim  = longint'(1) << (N-1);
            r.o  = f[0] ? (p < -lim || p >= lim) : (p >= (lim << 1));
            r.z  = (p == 0);
            r.n  = pv[2*N-1];
        end else if (ib == '0) begin
            r.y  = '1;
            r.yh = ia;
            r.d  = 1'b1;
            r.n  = 1'b1;
        end else if (f[0] && ia == MOST_NEG && ib == '1) begin
            r.y  = MOST_NEG;
            r.yh = '0;
            r.o  = 1'b1;
            r.n  = 1'b1;
        end else begin
            q    = sa / sb;
            rm   = sa % sb;
            pv   = q;
            r.y  = pv[N-1:0];
            pv   = rm;
            r.yh = pv[N-1:0];
            r.z  = (r.y == '0);
            r.n  = r.y[N-1];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 1;
            2: v = '1;
            3: v = MOST_NEG;
            4: v = ~MOST_NEG;
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    // Launch one operation (caller is at posedge+1 with the unit idle or in its done cycle)
    // and wait for done. edges counts the accept edge as 1.
    task automatic run_op(input logic [1:0] f, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          output res_t got, output int edges, output int busy_cyc, output bit to);
        func  = f;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        func  = 2'($urandom);
        edges = 1;
        busy_cyc = busy ? 1 : 0;
        to = 1'b0;
        while (!done) begin
            if (edges > 4*N) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cyc++;
        end
        got = {y, yhigh, zero, negative, overflow, div_by_zero};
    endtask

    task automatic test_reset();
        res_t got;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        func    = 2'b00;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {y, yhigh, zero, negative, overflow, div_by_zero};
        checks++;
        if (got !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got res=%h busy=%b done=%b, expected all zero", got, busy, done);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_unsigned();
        op_t  ops[$];
        res_t got, exp;
        int   edges, bc;
        bit   to;
        ops.push_back('{2'b00, 16'hFFFF, 16'hFFFF});
        ops.push_back('{2'b00, 16'h0000, 16'h1234});
        for (int i = 0; i < 4; i++) ops.push_back('{2'b00, N'($urandom), N'($urandom)});
        for (int i = 0; i < ops.size(); i++) begin
            exp = model(ops[i].f, ops[i].a, ops[i].b);
            run_op(ops[i].f, ops[i].a, ops[i].b, got, edges, bc, to);
            checks++;
            if (to || got !== exp) begin
                errors++;
                $display("FAIL mul_u %h*%h: got %h, expected %h (timeout=%0d)", ops[i].a, ops[i].b, got, exp, to);
            end
            checks++;
            if (edges != N+2 || bc != N+1) begin
                errors++;
                $display("FAIL mul_u_latency: got edges=%0d busy=%0d, expected %0d/%0d", edges, bc, N+2, N+1);
            end
        end
    endtask

    task automatic test_mul_signed();
        op_t  ops[$];
        res_t got, exp;
        int   edges, bc;
        bit   to;
        ops.push_back('{2'b01, 16'hFFFD, 16'h0005});
        ops.push_back('{2'b01, 16'h0000, 16'hFFF3});
        ops.push_back('{2'b01, MOST_NEG, MOST_NEG});
        ops.push_back('{2'b01, MOST_NEG, 16'h0001});
        for (int i = 0; i < 4; i++) ops.push_back('{2'b01, N'($urandom), N'($urandom)});
        for (int i = 0; i < ops.size(); i++) begin
            exp = model(ops[i].f, ops[i].a, ops[i].b);
            run_op(ops[i].f, ops[i].a, ops[i].b, got, edges, bc, to);
            checks++;
            if (to || got !== exp) begin
                errors++;
                $display("FAIL mul_s %h*%h: got %h, expected %h (timeout=%0d)", ops[i].a, ops[i].b, got, exp, to);
            end
        end
    endtask

    task automatic test_div();
        op_t  ops[$];
        res_t got, exp;
        int   edges, bc;
        bit   to;
        ops.push_back('{2'b11, 16'hFFF9, 16'h0002});
        ops.push_back('{2'b10, 16'h0064, 16'h0007});
        ops.push_back('{2'b11, 16'h0007, 16'hFFFE});
        ops.push_back('{2'b10, 16'h0003, 16'h0009});
        for (int i = 0; i < 3; i++) ops.push_back('{2'b10, N'($urandom), N'($urandom_range(1, 65535))});
        for (int i = 0; i < 3; i++) ops.push_back('{2'b11, N'($urandom), N'($urandom_range(1, 65535))});
        for (int i = 0; i < ops.size(); i++) begin
            exp = model(ops[i].f, ops[i].a, ops[i].b);
            run_op(ops[i].f, ops[i].a, ops[i].b, got, edges, bc, to);
            checks++;
            if (to || got !== exp) begin
                errors++;
                $display("FAIL div f=%b %h/%h: got %h, expected %h (timeout=%0d)", ops[i].f, ops[i].a, ops[i].b, got, exp, to);
            end
        end
    endtask

    task automatic test_div_boundary();
        op_t  ops[$];
        res_t got, exp;
        int   edges, bc;
        bit   to;
        ops.push_back('{2'b10, 16'h1234, 16'h0000});
        ops.push_back('{2'b11, MOST_NEG, 16'hFFFF});
        ops.push_back('{2'b11, 16'hFFF0, 16'h0000});
        ops.push_back('{2'b10, MOST_NEG, 16'hFFFF});
        ops.push_back('{2'b11, MOST_NEG, 16'h0001});
        for (int i = 0; i < ops.size(); i++) begin
            exp = model(ops[i].f, ops[i].a, ops[i].b);
            run_op(ops[i].f, ops[i].a, ops[i].b, got, edges, bc, to);
            checks++;
            if (to || got !== exp) begin
                errors++;
                $display("FAIL div_edge f=%b %h/%h: got %h, expected %h (timeout=%0d)", ops[i].f, ops[i].a, ops[i].b, got, exp, to);
            end
            checks++;
            if (edges != N+2) begin
                errors++;
                $display("FAIL div_edge_latency: got edges=%0d, expected %0d", edges, N+2);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        int   edges, bc;
        bit   to;
        bit   done_at_launch;
        run_op(2'b00, 16'h0102, 16'h0304, got, edges, bc, to);
        done_at_launch = done;
        exp = model(2'b11, 16'h8765, 16'h0013);
        run_op(2'b11, 16'h8765, 16'h0013, got, edges, bc, to);
        checks++;
        if (!done_at_launch || to || got !== exp || edges != N+2) begin
            errors++;
            $display("FAIL back_to_back: got %h edges=%0d launch_in_done=%b, expected %h edges=%0d",
                     got, edges, done_at_launch, exp, N+2);
        end
    endtask

    task automatic test_start_while_busy();
        res_t got, exp;
        int   k;
        int   extra_done, extra_busy;
        exp   = model(2'b00, 16'h00FF, 16'h0101);
        func  = 2'b00;
        a     = 16'h00FF;
        b     = 16'h0101;
        start = 1'b1;
        @(posedge clk); #1;
        k = 1;
        while (!done && k <= 4*N) begin
            start = (k <= N) ? 1'($urandom) : 1'b0;
            a     = N'($urandom);
            b     = N'($urandom);
            func  = 2'($urandom);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        got = {y, yhigh, zero, negative, overflow, div_by_zero};
        checks++;
        if (got !== exp || k != N+2) begin
            errors++;
            $display("FAIL start_while_busy: got %h edges=%0d, expected %h edges=%0d", got, k, exp, N+2);
        end
        extra_done = 0;
        extra_busy = 0;
        repeat (2*N + 4) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++;
        if (extra_done != 0 || extra_busy != 0) begin
            errors++;
            $display("FAIL start_not_queued: got done=%0d busy=%0d cycles, expected 0/0", extra_done, extra_busy);
        end
    endtask

    task automatic test_flush();
        res_t prev, got, exp;
        int   edges, bc, dn;
        bit   to;
        exp = model(2'b00, 16'h1234, 16'h0042);
        run_op(2'b00, 16'h1234, 16'h0042, prev, edges, bc, to);
        checks++;
        if (to || prev !== exp) begin
            errors++;
            $display("FAIL flush_setup: got %h, expected %h", prev, exp);
            prev = exp;
        end
        func  = 2'b00;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        got = {y, yhigh, zero, negative, overflow, div_by_zero};
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || got !== prev) begin
            errors++;
            $display("FAIL flush_abort: got busy=%b done=%b res=%h, expected 0/0/%h", busy, done, got, prev);
        end
        dn = 0;
        repeat (2*N) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d done pulses, expected 0", dn);
        end
        // flush in IDLE blocks a simultaneous start
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_start: got busy=%b, expected 0", busy);
        end
        exp = model(2'b10, 16'hBEEF, 16'h0123);
        run_op(2'b10, 16'hBEEF, 16'h0123, got, edges, bc, to);
        checks++;
        if (to || got !== exp || edges != N+2) begin
            errors++;
            $display("FAIL after_flush: got %h edges=%0d, expected %h edges=%0d", got, edges, exp, N+2);
        end
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        int   edges, bc, dn, bz;
        bit   to;
        func  = 2'b01;
        a     = 16'hFFFD;
        b     = 16'h7001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        got = {y, yhigh, zero, negative, overflow, div_by_zero};
        checks++;
        if (got !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got res=%h busy=%b done=%b, expected all zero", got, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        dn = 0;
        bz = 0;
        repeat (2*N) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (busy) bz++;
        end
        checks++;
        if (dn != 0 || bz != 0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%0d busy=%0d cycles, expected 0/0", dn, bz);
        end
        exp = model(2'b01, 16'hFFFD, 16'h7001);
        run_op(2'b01, 16'hFFFD, 16'h7001, got, edges, bc, to);
        checks++;
        if (to || got !== exp || edges != N+2) begin
            errors++;
            $display("FAIL after_reset: got %h edges=%0d, expected %h edges=%0d", got, edges, exp, N+2);
        end
    endtask

    task automatic test_random();
        res_t got, exp;
        int   edges, bc;
        bit   to;
        logic [1:0]   f;
        logic [N-1:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            f  = 2'($urandom);
            ra = pick();
            rb = pick();
            exp = model(f, ra, rb);
            run_op(f, ra, rb, got, edges, bc, to);
            checks++;
            if (to || got !== exp || edges != N+2) begin
                errors++;
                $display("FAIL random f=%b a=%h b=%h: got %h edges=%0d, expected %h edges=%0d",
                         f, ra, rb, got, edges, exp, N+2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div();
        test_div_boundary();
        test_back_to_back();
        test_start_while_busy();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
